// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the multi-cycle divider.
// Execute raises start_i and holds it (with the operands) until ready_o is seen.
interface div_unit_if #(
    parameter int DATA_W = 32
);
    logic                  signed_div_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  start_i;
    logic                  annul_i;
    logic [2*DATA_W-1:0]   result_o;
    logic                  ready_o;
    logic [1:0]            state_dbg;

    // Handshake: a request is accepted on the first rising edge where start_i=1,
    // annul_i=0 and the divider is idle. ready_o then stays high with a stable
    // result_o until start_i drops; the divider returns to idle on that edge.
    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, state_dbg
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, state_dbg
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle, sign fix-up
// on the final ON cycle, result {remainder, quotient} held until start_i drops.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic [DATA_W-1:0]     quo_q, quo_d;
    logic [DATA_W-1:0]     dvs_mag_q, dvs_mag_d;
    logic                  is_signed_q, is_signed_d;
    logic                  dvd_neg_q, dvd_neg_d;
    logic                  dvs_neg_q, dvs_neg_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    // The partial remainder is always below the divisor after each step, so only
    // DATA_W bits are stored; the shifted value needs the extra top bit.
    logic [DATA_W:0]       rem_sh;
    logic                  sub_ok;
    logic [DATA_W-1:0]     dvd_mag, dvs_mag, quo_fix, rem_fix;
    logic                  op1_neg, op2_neg;

    assign op1_neg = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    assign op2_neg = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    assign dvd_mag = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    assign dvs_mag = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;

    assign rem_sh  = {rem_q, quo_q[DATA_W-1]};
    assign sub_ok  = (rem_sh >= {1'b0, dvs_mag_q});

    assign quo_fix = (is_signed_q && (dvd_neg_q != dvs_neg_q)) ? (~quo_q + 1'b1) : quo_q;
    assign rem_fix = (is_signed_q && dvd_neg_q) ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_mag_d   = dvs_mag_q;
        is_signed_d = is_signed_q;
        dvd_neg_d   = dvd_neg_q;
        dvs_neg_d   = dvs_neg_q;
        result_d    = result_q;
        ready_d     = ready_q;

        unique case (state_q)
            ST_FREE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d     = ST_ON;
                        cnt_d       = '0;
                        rem_d       = '0;
                        quo_d       = dvd_mag;
                        dvs_mag_d   = dvs_mag;
                        is_signed_d = bus.signed_div_i;
                        dvd_neg_d   = op1_neg;
                        dvs_neg_d   = op2_neg;
                    end
                end
            end
            ST_BYZERO: begin
                state_d  = ST_END;
                result_d = '0;
                ready_d  = 1'b1;
            end
            ST_ON: begin
                if (bus.annul_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    // Restoring step: subtract only when the shifted remainder fits.
                    rem_d = sub_ok ? (rem_sh[DATA_W-1:0] - dvs_mag_q) : rem_sh[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], sub_ok};
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    state_d  = ST_END;
                    ready_d  = 1'b1;
                    result_d = {rem_fix, quo_fix};
                end
            end
            ST_END: begin
                if (!bus.start_i) begin
                    state_d  = ST_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end
            default: state_d = ST_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_FREE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_mag_q   <= '0;
            is_signed_q <= 1'b0;
            dvd_neg_q   <= 1'b0;
            dvs_neg_q   <= 1'b0;
            result_q    <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_mag_q   <= dvs_mag_d;
            is_signed_q <= is_signed_d;
            dvd_neg_q   <= dvd_neg_d;
            dvs_neg_q   <= dvs_neg_d;
            result_q    <= result_d;
            ready_q     <= ready_d;
        end
    end

    assign bus.result_o  = result_q;
    assign bus.ready_o   = ready_q;
    assign bus.state_dbg = state_q;
endmodule
